memory_bus_arbiter: RTL and testbench
=====================================

# memory_bus_arbiter

Two-port front end for the combined text/data memory bus. It arbitrates between the instruction-fetch port and the load/store port, sequences each access over the bus's synchronous-read timing, and returns one-cycle acknowledge pulses with read data. It also rejects illegal accesses before they reach the bus. It sits between the core and `example_memory_bus`, and its `bus_*` outputs connect directly to that bus's ports.

## Interface
- No parameters. Region bounds come from config macros `TEXT_BEGIN`/`TEXT_END`/`DATA_BEGIN`/`DATA_END`.
- `clock` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `fetch_req` in 1: fetch request; held with `fetch_address` until `fetch_ack`.
- `fetch_address` in 32: fetch byte address.
- `fetch_ack` out 1: one-cycle completion pulse.
- `fetch_error` out 1: valid with `fetch_ack`; set for a misaligned fetch.
- `fetch_data` out 32: instruction word; valid with `fetch_ack`, else 0.
- `data_req` in 1: load/store request; held with its qualifiers until `data_ack`.
- `data_address` in 32: byte address.
- `data_write` in 1: 1 = store, 0 = load.
- `data_byte_enable` in 4: lane mask, already lane-aligned by the requester.
- `data_write_data` in 32: lane-aligned store data.
- `data_ack` out 1: one-cycle completion pulse.
- `data_error` out 1: valid with `data_ack`.
- `data_read_data` out 32: load word; valid with `data_ack`, else 0.
- `bus_address` out 32, `bus_write_data` out 32, `bus_byte_enable` out 4, `bus_read_enable` out 1, `bus_write_enable` out 1: drive the memory bus.
- `bus_read_data` in 32: combinational bus return.

## Operation
- FSM has three states: IDLE, ISSUE and RESPOND.
- **IDLE**
  - If any request is present, latch the granted port's address, write flag, byte enables and write data into internal registers, then go to ISSUE.
  - If no request is present, stay in IDLE.
- **Arbitration**
  - If only one port requests, that port is granted.
  - If both request, grant the port not granted last.
  - The last-grant register resets to "fetch", so the first contention goes to data.
- **Error checks** are evaluated on latch. An errored access runs the same ISSUE/RESPOND sequence with both bus enables held low.
  - Fetch: `fetch_address[1:0] != 0`.
  - Data: a store outside `DATA_BEGIN..DATA_END`.
  - Data: `data_byte_enable == 0`.
  - Data: an address outside both regions.
- **ISSUE**
  - Drive `bus_*` from the latched registers.
  - Read: `bus_read_enable` = 1. Write: `bus_write_enable` = 1 and `bus_byte_enable` = latched mask.
  - Always go to RESPOND.
- **RESPOND**
  - Hold `bus_address`. This is mandatory, because the bus's read mux decodes the current address.
  - Read: keep `bus_read_enable` = 1. `bus_write_enable` = 0 in all cases.
  - Pulse the granted port's ack. Drive its read-data output from `bus_read_data` for a successful read; otherwise drive 0.
  - Update the last-grant register, then go to IDLE.
- **Requester rule**
  - A requester's `req` seen in the RESPOND cycle belongs to the transaction being acked.
  - The next request is sampled in IDLE on the following cycle.
- **Reset**
  - Reset mid-operation returns immediately to IDLE and aborts the transaction with no ack.
  - A store caught in ISSUE may or may not have committed.
  - The requester re-issues after reset.
- **Reset values**: all outputs 0; internal registers 0; last-grant = fetch.

## Timing
- Request sampled in IDLE at cycle 0, ISSUE at cycle 1, ack at cycle 2.
- Fixed latency of 2 cycles, including errors.
- Throughput is one access per 3 cycles. Ports never get consecutive grants under contention.
- A write commits at the clock edge that ends ISSUE, and is acked in the following cycle.
- `bus_write_enable` is high for exactly one cycle per store.
- `bus_read_enable` is high for exactly two cycles per load or fetch.
- `*_ack` and `*_error` are registered-state decodes, one cycle wide, and never both ports in the same cycle.

## Structure
- Shared package `memory_bus_pkg`:
  - `bus_state_t` enum: IDLE, ISSUE, RESPOND.
  - `bus_port_t` enum: PORT_FETCH, PORT_DATA.
  - Region-check functions `in_text(addr)` and `in_data(addr)` built on the config macros.
- Single module; no sub-module is warranted. The two-way round-robin is a single flop plus a mux.

## Test plan
Bench config: TEXT 0x0000_0000–0x0000_FFFF, DATA 0x0001_0000–0x0001_FFFF.

- Fetch 0x0000_0004, text word = 0x0050_0093 -> `fetch_ack` at cycle 2, `fetch_data` = 0x0050_0093, `bus_read_enable` high for cycles 1–2, address held.
- Store 0xDEAD_BEEF with byte enables 4'b0011 to 0x0001_0010, then load the same address -> `bus_write_enable` for one cycle; load returns 0x0000_BEEF after reset-cleared memory.
- `fetch_req` and `data_req` both asserted continuously from reset -> grants alternate data, fetch, data, fetch; acks 3 cycles apart; never two acks in one cycle.
- Fetch 0x0000_0006, and separately a store to 0x0000_0100 -> ack at cycle 2 with error = 1, data = 0, no bus enable ever asserted.
- `reset_n` driven low during the ISSUE cycle of a load -> no ack, all outputs 0 asynchronously; after release, a held `data_req` completes normally in 2 cycles.

Source files
------------

// File: rtl/memory_bus_pkg.sv
// Shared types and region checks for the text/data memory bus front end.
// Region bounds default to the standard map unless the build overrides the macros.
`ifndef TEXT_BEGIN
`define TEXT_BEGIN 32'h0000_0000
`endif
`ifndef TEXT_END
`define TEXT_END 32'h0000_FFFF
`endif
`ifndef DATA_BEGIN
`define DATA_BEGIN 32'h0001_0000
`endif
`ifndef DATA_END
`define DATA_END 32'h0001_FFFF
`endif

package memory_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESPOND
  } bus_state_t;

  typedef enum logic {
    PORT_FETCH,
    PORT_DATA
  } bus_port_t;

  localparam logic [31:0] TEXT_LO = `TEXT_BEGIN;
  localparam logic [31:0] TEXT_HI = `TEXT_END;
  localparam logic [31:0] DATA_LO = `DATA_BEGIN;
  localparam logic [31:0] DATA_HI = `DATA_END;

  // Offset form keeps a zero-based region from degenerating into a constant compare.
  function automatic logic in_text(input logic [31:0] addr);
    return (addr - TEXT_LO) <= (TEXT_HI - TEXT_LO);
  endfunction

  function automatic logic in_data(input logic [31:0] addr);
    return (addr - DATA_LO) <= (DATA_HI - DATA_LO);
  endfunction

endpackage

// File: rtl/memory_bus_arbiter.sv
// Two-port (fetch, load/store) arbiter and sequencer for the synchronous-read memory bus.
// Every access, including rejected ones, takes IDLE -> ISSUE -> RESPOND with the ack in RESPOND.
module memory_bus_arbiter
  import memory_bus_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_address,
  output logic        fetch_ack,
  output logic        fetch_error,
  output logic [31:0] fetch_data,
  input  logic        data_req,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic [3:0]  data_byte_enable,
  input  logic [31:0] data_write_data,
  output logic        data_ack,
  output logic        data_error,
  output logic [31:0] data_read_data,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  input  logic [31:0] bus_read_data
);

  bus_state_t  state_q, state_d;
  bus_port_t   grant_q, grant_d;
  bus_port_t   last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        write_q, write_d;
  logic        err_q, err_d;

  logic        fetch_bad;
  logic        data_bad;
  bus_port_t   pick;
  logic        rd_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= PORT_FETCH;
      last_q  <= PORT_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    fetch_bad = fetch_address[1:0] != 2'b00;
    data_bad  = (data_write && !in_data(data_address))
             || (data_byte_enable == 4'b0000)
             || (!in_text(data_address) && !in_data(data_address));

    // Under contention the port that lost last time wins.
    if (fetch_req && data_req) begin
      pick = (last_q == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
    end else if (data_req) begin
      pick = PORT_DATA;
    end else begin
      pick = PORT_FETCH;
    end

    rd_ok = !err_q && !write_q;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    write_d = write_q;
    err_d   = err_q;

    fetch_ack        = 1'b0;
    fetch_error      = 1'b0;
    fetch_data       = '0;
    data_ack         = 1'b0;
    data_error       = 1'b0;
    data_read_data   = '0;
    bus_address      = '0;
    bus_write_data   = '0;
    bus_byte_enable  = '0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;

    case (state_q)
      IDLE: begin
        if (fetch_req || data_req) begin
          grant_d = pick;
          state_d = ISSUE;
          if (pick == PORT_FETCH) begin
            addr_d  = fetch_address;
            write_d = 1'b0;
            be_d    = 4'b1111;
            wdata_d = '0;
            err_d   = fetch_bad;
          end else begin
            addr_d  = data_address;
            write_d = data_write;
            be_d    = data_byte_enable;
            wdata_d = data_write_data;
            err_d   = data_bad;
          end
        end
      end

      ISSUE: begin
        bus_address = addr_q;
        if (!err_q) begin
          if (write_q) begin
            bus_write_enable = 1'b1;
            bus_byte_enable  = be_q;
            bus_write_data   = wdata_q;
          end else begin
            bus_read_enable = 1'b1;
          end
        end
        state_d = RESPOND;
      end

      RESPOND: begin
        // The bus read mux decodes the live address, so it stays on the bus here.
        bus_address     = addr_q;
        bus_read_enable = rd_ok;
        if (grant_q == PORT_FETCH) begin
          fetch_ack   = 1'b1;
          fetch_error = err_q;
          fetch_data  = rd_ok ? bus_read_data : '0;
        end else begin
          data_ack       = 1'b1;
          data_error     = err_q;
          data_read_data = rd_ok ? bus_read_data : '0;
        end
        last_d  = grant_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: directed vector table, contention and reset sequences,
// then randomized traffic against a transaction-level reference with its own memory image.
module tb_memory_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_address = '0;
  logic        fetch_ack, fetch_error;
  logic [31:0] fetch_data;
  logic        data_req = 1'b0;
  logic [31:0] data_address = '0;
  logic        data_write = 1'b0;
  logic [3:0]  data_byte_enable = '0;
  logic [31:0] data_write_data = '0;
  logic        data_ack, data_error;
  logic [31:0] data_read_data;
  logic [31:0] bus_address, bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable, bus_write_enable;
  logic [31:0] bus_read_data;

  int checks = 0;
  int errors = 0;

  memory_bus_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_address(fetch_address),
    .fetch_ack(fetch_ack), .fetch_error(fetch_error), .fetch_data(fetch_data),
    .data_req(data_req), .data_address(data_address), .data_write(data_write),
    .data_byte_enable(data_byte_enable), .data_write_data(data_write_data),
    .data_ack(data_ack), .data_error(data_error), .data_read_data(data_read_data),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_byte_enable(bus_byte_enable), .bus_read_enable(bus_read_enable),
    .bus_write_enable(bus_write_enable), .bus_read_data(bus_read_data)
  );

  always #5 clock = ~clock;

  // Fixed text image: word 1 holds the instruction from the fetch example.
  function automatic logic [31:0] text_word(input logic [5:0] i);
    if (i == 6'd1) return 32'h0050_0093;
    return 32'hA500_0000 | ({26'd0, i} * 32'h0001_0203);
  endfunction

  // Bus stand-in: combinational read, byte-lane write at the clock edge.
  logic [31:0] dmem [0:63] = '{default: 32'h0};

  always_comb begin
    bus_read_data = '0;
    if (bus_address <= 32'h0000_00FF) bus_read_data = text_word(bus_address[7:2]);
    else if (bus_address[31:8] == 24'h000100) bus_read_data = dmem[bus_address[7:2]];
  end

  always @(posedge clock) begin
    if (bus_write_enable && bus_address[31:8] == 24'h000100) begin
      for (int b = 0; b < 4; b++)
        if (bus_byte_enable[b]) dmem[bus_address[7:2]][8*b +: 8] <= bus_write_data[8*b +: 8];
    end
  end

  // Reference memory image for the data region.
  logic [31:0] rmem [0:63];

  function automatic bit in_rng(input logic [31:0] a, input logic [31:0] lo, input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (a <= 32'h0000_00FF) return text_word(a[7:2]);
    if (in_rng(a, 32'h0001_0000, 32'h0001_00FF)) return rmem[a[7:2]];
    return 32'h0;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    if (in_rng(a, 32'h0001_0000, 32'h0001_00FF))
      for (int b = 0; b < 4; b++)
        if (be[b]) rmem[a[7:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  function automatic bit ref_data_err(input logic [31:0] a, input logic wr, input logic [3:0] be);
    bit it, id;
    it = in_rng(a, 32'h0000_0000, 32'h0000_FFFF);
    id = in_rng(a, 32'h0001_0000, 32'h0001_FFFF);
    return (wr && !id) || (be == 4'b0000) || (!it && !id);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    fetch_req = 1'b0; fetch_address = '0;
    data_req = 1'b0; data_address = '0; data_write = 1'b0;
    data_byte_enable = '0; data_write_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    clear_inputs();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        is_data;
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic run_vec(input vec_t v, input int idx);
    logic exp_re, exp_we;
    exp_re = !v.exp_err && !v.wr;
    exp_we = !v.exp_err && v.wr;
    if (v.is_data) begin
      data_req = 1'b1; data_address = v.addr; data_write = v.wr;
      data_byte_enable = v.be; data_write_data = v.wdata;
    end else begin
      fetch_req = 1'b1; fetch_address = v.addr;
    end
    chk($sformatf("v%0d_c0_ack", idx), {30'd0, fetch_ack, data_ack}, 32'd0);
    @(negedge clock);
    chk($sformatf("v%0d_c1_en", idx), {30'd0, bus_read_enable, bus_write_enable}, {30'd0, exp_re, exp_we});
    chk($sformatf("v%0d_c1_ack", idx), {30'd0, fetch_ack, data_ack}, 32'd0);
    if (exp_re || exp_we) chk($sformatf("v%0d_c1_addr", idx), bus_address, v.addr);
    if (exp_we) chk($sformatf("v%0d_c1_be", idx), {28'd0, bus_byte_enable}, {28'd0, v.be});
    @(negedge clock);
    chk($sformatf("v%0d_c2_ack", idx), {30'd0, fetch_ack, data_ack},
        v.is_data ? 32'd1 : 32'd2);
    chk($sformatf("v%0d_c2_err", idx), {31'd0, v.is_data ? data_error : fetch_error}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_c2_rdata", idx), v.is_data ? data_read_data : fetch_data, v.exp_rdata);
    chk($sformatf("v%0d_c2_en", idx), {30'd0, bus_read_enable, bus_write_enable}, {30'd0, exp_re, 1'b0});
    if (exp_re) chk($sformatf("v%0d_c2_addr", idx), bus_address, v.addr);
    clear_inputs();
    if (exp_we) ref_write(v.addr, v.be, v.wdata);
    @(negedge clock);
    chk($sformatf("v%0d_c3_ack", idx), {30'd0, fetch_ack, data_ack}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rmem[i] = 32'h0;

    vecs[0]  = '{1'b0, 32'h0000_0004, 1'b0, 4'hF, 32'h0,         1'b0, 32'h0050_0093};
    vecs[1]  = '{1'b1, 32'h0001_0010, 1'b1, 4'h3, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h0001_0010, 1'b0, 4'hF, 32'h0,         1'b0, 32'h0000_BEEF};
    vecs[3]  = '{1'b0, 32'h0000_0006, 1'b0, 4'hF, 32'h0,         1'b1, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0100, 1'b1, 4'hF, 32'h1111_2222, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 32'h0001_0020, 1'b0, 4'h0, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'h0002_0000, 1'b0, 4'hF, 32'h0,         1'b1, 32'h0};
    vecs[7]  = '{1'b1, 32'h0001_0000, 1'b1, 4'hC, 32'h1234_5678, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h0001_0000, 1'b0, 4'hF, 32'h0,         1'b0, 32'h1234_0000};
    vecs[9]  = '{1'b1, 32'h0000_FFFC, 1'b1, 4'hF, 32'h5555_AAAA, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 32'h0000_0008, 1'b0, 4'hF, 32'h0,         1'b0, text_word(6'd2)};
    vecs[11] = '{1'b0, 32'h0000_003C, 1'b0, 4'hF, 32'h0,         1'b0, text_word(6'd15)};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_acks", {28'd0, fetch_ack, data_ack, fetch_error, data_error}, 32'd0);
    chk("rst_bus_en", {30'd0, bus_read_enable, bus_write_enable}, 32'd0);
    chk("rst_bus_addr", bus_address, 32'd0);
    chk("rst_data", fetch_data | data_read_data | bus_write_data, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Continuous contention from reset: data, fetch, data, fetch, acks 3 cycles apart
    @(negedge clock);
    reset_n = 1'b0;
    fetch_req = 1'b1; fetch_address = 32'h0000_0004;
    data_req = 1'b1; data_address = 32'h0001_0010; data_write = 1'b0; data_byte_enable = 4'hF;
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      logic [31:0] exp_ack;
      if (k > 0) @(negedge clock);
      exp_ack = (k % 3 != 2) ? 32'd0 : (((k / 3) % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("cont_k%0d_ack", k), {30'd0, fetch_ack, data_ack}, exp_ack);
      if (exp_ack == 32'd1) chk($sformatf("cont_k%0d_ddata", k), data_read_data, 32'h0000_BEEF);
      if (exp_ack == 32'd2) chk($sformatf("cont_k%0d_fdata", k), fetch_data, 32'h0050_0093);
    end
    clear_inputs();

    // Reset asserted during the ISSUE cycle of a load
    @(negedge clock);
    data_req = 1'b1; data_address = 32'h0001_0010; data_write = 1'b0; data_byte_enable = 4'hF;
    @(negedge clock);
    chk("rmid_issue_re", {31'd0, bus_read_enable}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rmid_async_ctl", {28'd0, fetch_ack, data_ack, bus_read_enable, bus_write_enable}, 32'd0);
    chk("rmid_async_addr", bus_address, 32'd0);
    @(negedge clock);
    chk("rmid_no_ack", {30'd0, fetch_ack, data_ack}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rmid_c1_ack", {30'd0, fetch_ack, data_ack}, 32'd0);
    @(negedge clock);
    chk("rmid_c2_ack", {30'd0, fetch_ack, data_ack}, 32'd1);
    chk("rmid_c2_data", data_read_data, 32'h0000_BEEF);
    chk("rmid_c2_err", {31'd0, data_error}, 32'd0);
    clear_inputs();

    // Randomized traffic against the transaction-level reference
    do_reset();
    begin
      int          ack_c, free_c;
      bit          last_data, m_data, m_wr, m_err;
      logic [31:0] m_addr, m_rdata, exp_ack;
      logic        exp_re, exp_we;
      ack_c = -100; free_c = 0; last_data = 1'b0;
      m_data = 1'b0; m_wr = 1'b0; m_err = 1'b1; m_addr = '0; m_rdata = '0;
      for (int c = 0; c < 600; c++) begin
        if (c > 0) @(negedge clock);
        exp_ack = (c == ack_c) ? (m_data ? 32'd1 : 32'd2) : 32'd0;
        chk("rnd_ack", {30'd0, fetch_ack, data_ack}, exp_ack);
        if (c == ack_c) begin
          chk("rnd_err", {31'd0, m_data ? data_error : fetch_error}, {31'd0, m_err});
          chk("rnd_rdata", m_data ? data_read_data : fetch_data, m_rdata);
        end else begin
          chk("rnd_idle_rdata", fetch_data | data_read_data, 32'd0);
        end
        exp_re = ((c == ack_c - 1) || (c == ack_c)) && !m_wr && !m_err;
        exp_we = (c == ack_c - 1) && m_wr && !m_err;
        chk("rnd_bus_en", {30'd0, bus_read_enable, bus_write_enable}, {30'd0, exp_re, exp_we});
        if (exp_re || exp_we) chk("rnd_bus_addr", bus_address, m_addr);

        if (c == ack_c) begin
          if (m_data) data_req = 1'b0;
          else fetch_req = 1'b0;
        end
        if (!fetch_req && $urandom_range(0, 1) == 1) begin
          int fa;
          fa = 4 * $urandom_range(0, 15);
          if ($urandom_range(0, 3) == 0) fa = fa + $urandom_range(1, 3);
          fetch_req = 1'b1;
          fetch_address = 32'(fa);
        end
        if (!data_req && $urandom_range(0, 1) == 1) begin
          int sel;
          sel = $urandom_range(0, 5);
          case (sel)
            0, 1, 2: data_address = 32'h0001_0000 + 32'(4 * $urandom_range(0, 15));
            3:       data_address = 32'(4 * $urandom_range(0, 15));
            4:       data_address = 32'h0002_0000;
            default: data_address = 32'h0000_FFFC;
          endcase
          data_req = 1'b1;
          data_write = 1'($urandom_range(0, 1));
          data_byte_enable = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          data_write_data = $urandom;
        end

        if (c >= free_c && (fetch_req || data_req)) begin
          m_data = (fetch_req && data_req) ? !last_data : data_req;
          if (m_data) begin
            m_addr = data_address;
            m_wr   = data_write;
            m_err  = ref_data_err(data_address, data_write, data_byte_enable);
            if (m_wr && !m_err) ref_write(data_address, data_byte_enable, data_write_data);
          end else begin
            m_addr = fetch_address;
            m_wr   = 1'b0;
            m_err  = fetch_address[1:0] != 2'b00;
          end
          m_rdata   = (m_wr || m_err) ? 32'h0 : ref_read(m_addr);
          last_data = m_data;
          ack_c     = c + 2;
          free_c    = c + 3;
        end
      end
    end
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

endmodule
